// File: rtl/cnn_result_reader.sv
// Avalon-MM read-back peripheral: CNN core pushes result bytes into a FIFO, the HPS pops/polls them.
// Optional level interrupt on FIFO fill level or overflow is enabled with `define CNN_RD_IRQ_EN.
module cnn_result_reader #(
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic [7:0] res_data,
    input  logic       res_valid
`ifdef CNN_RD_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_PEEK   = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          empty;
    logic          full;
    logic          rd_acc;
    logic          wr_acc;
    logic          pop;
    logic          flush;
    logic          clr_ovf;
    logic          push_ok;
    logic          push_drop;
    logic [7:0]    ctrl_rd;
    logic [7:0]    rd_next;

    // res_valid is a one-cycle push strobe with no backpressure: a byte offered while
    // the FIFO is full (and no pop frees a slot) is dropped and flagged as overflow.
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign rd_acc  = chipselect && read;
    assign wr_acc  = chipselect && write && !read;
    assign pop     = rd_acc && (address == ADDR_DATA) && !empty;
    assign flush   = wr_acc && (address == ADDR_CTRL) && writedata[0];
    assign clr_ovf = wr_acc && (address == ADDR_CTRL) && writedata[1];
    // A pop on the same edge frees the slot the push needs; flush discards the byte outright.
    assign push_ok   = res_valid && !flush && (!full || pop);
    assign push_drop = res_valid && !flush && full && !pop;

`ifdef CNN_RD_IRQ_EN
    logic irq_en;
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata[7:3]};
    assign ctrl_rd   = {5'b0, irq_en, 2'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_acc && (address == ADDR_CTRL)) irq_en <= writedata[2];
            irq <= irq_en && ((count >= CW'(IRQ_THRESH)) || overflow);
        end
    end
`else
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata[7:2]};
    assign ctrl_rd   = 8'h00;
`endif

    always_comb begin
        rd_next = readdata;
        if (rd_acc) begin
            case (address)
                ADDR_DATA:   rd_next = empty ? 8'h00 : mem[rd_ptr];
                ADDR_STATUS: rd_next = {empty, full, overflow, 5'(count)};
                ADDR_CTRL:   rd_next = ctrl_rd;
                ADDR_PEEK:   rd_next = empty ? 8'h00 : mem[rd_ptr];
                default:     rd_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= res_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            readdata <= 8'h00;
        end else begin
            readdata <= rd_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push_ok) - CW'(pop);
            end
            // A drop in the same cycle as a clear keeps the flag set so the loss is not hidden.
            if (push_drop)    overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Bench for cnn_result_reader: directed scenarios plus random traffic against a queue-based model.
module tb_cnn_result_reader;

    localparam int DEPTH  = 16;
    localparam int THRESH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       chipselect = 1'b0;
    logic [1:0] address = 2'd0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic [7:0] res_data = 8'h00;
    logic       res_valid = 1'b0;
`ifdef CNN_RD_IRQ_EN
    logic       irq;
`endif

    cnn_result_reader #(.DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .res_data(res_data),
        .res_valid(res_valid)
`ifdef CNN_RD_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] exp_rd = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_irq_en = 1'b0;
    logic       exp_irq = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0; m_irq_en = 1'b0; exp_irq = 1'b0; exp_rd = 8'h00;
    endtask

    // Behavioural model of one bus/push cycle, written directly from the register rules.
    task automatic model_step(input logic cs, input logic rd, input logic wr, input logic [1:0] addr,
                              input logic [7:0] wd, input logic rv, input logic [7:0] rdat);
        int  size0;
        logic rd_acc, wr_acc, popping, flush;
        size0   = exp_q.size();
        exp_irq = m_irq_en && (size0 >= THRESH || m_ovf);
        rd_acc  = cs && rd;
        wr_acc  = cs && wr && !rd;
        popping = 1'b0;
        flush   = wr_acc && addr == 2'd2 && wd[0];
        if (rd_acc) begin
            case (addr)
                2'd0: if (size0 > 0) begin exp_rd = exp_q.pop_front(); popping = 1'b1; end
                      else exp_rd = 8'h00;
                2'd1: exp_rd = {size0 == 0, size0 == DEPTH, m_ovf, 5'(size0)};
                2'd2: exp_rd = {5'b0, m_irq_en, 2'b0};
                default: exp_rd = (size0 > 0) ? exp_q[0] : 8'h00;
            endcase
        end
        if (wr_acc && addr == 2'd2) begin
            if (wd[1]) m_ovf = 1'b0;
`ifdef CNN_RD_IRQ_EN
            m_irq_en = wd[2];
`endif
        end
        if (flush) exp_q.delete();
        if (rv && !flush) begin
            if (size0 < DEPTH || popping) exp_q.push_back(rdat);
            else m_ovf = 1'b1;
        end
    endtask

    // Called at a negedge; applies inputs across one posedge and returns at the next negedge.
    task automatic drive(input logic cs, input logic rd, input logic wr, input logic [1:0] addr,
                         input logic [7:0] wd, input logic rv, input logic [7:0] rdat);
        chipselect = cs; read = rd; write = wr; address = addr; writedata = wd;
        res_valid = rv; res_data = rdat;
        model_step(cs, rd, wr, addr, wd, rv, rdat);
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0; res_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, b);
    endtask

    task automatic rd_reg(input logic [1:0] addr);
        drive(1'b1, 1'b1, 1'b0, addr, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic wr_ctrl(input logic [7:0] v);
        drive(1'b1, 1'b0, 1'b1, 2'd2, v, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL reset readdata: got %h exp 00", readdata); end
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL reset status: got %h exp 80", readdata); end
        push(8'hC1); push(8'hC2); push(8'hC3);
        rd_reg(2'd3);
        n_cmp++; if (readdata !== exp_rd) begin n_err++; $display("FAIL pre-reset peek: got %h exp %h", readdata, exp_rd); end
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL readdata in reset: got %h exp 00", readdata); end
        @(negedge clk);
        reset = 1'b1;
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL post-reset status: got %h exp 80", readdata); end
        rd_reg(2'd0);
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL post-reset data: got %h exp 00", readdata); end
    endtask

    task automatic test_order_wrap();
        push(8'h11); push(8'h22); push(8'h33);
        for (int i = 0; i < 3; i++) begin
            rd_reg(2'd0);
            n_cmp++; if (readdata !== exp_rd) begin n_err++; $display("FAIL order pop%0d: got %h exp %h", i, readdata, exp_rd); end
        end
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h50) begin n_err++; $display("FAIL wrap full status: got %h exp 50", readdata); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg(2'd0);
            n_cmp++; if (readdata !== exp_rd) begin n_err++; $display("FAIL wrap pop%0d: got %h exp %h", i, readdata, exp_rd); end
        end
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL wrap empty status: got %h exp 80", readdata); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        push(8'hAA);
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h70) begin n_err++; $display("FAIL overflow status: got %h exp 70", readdata); end
        rd_reg(2'd3);
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL overflow head: got %h exp 00", readdata); end
        wr_ctrl(8'h02);
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h50) begin n_err++; $display("FAIL overflow clear: got %h exp 50", readdata); end
        wr_ctrl(8'h01);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 255)));
        drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'hBB);
        n_cmp++; if (readdata !== exp_rd) begin n_err++; $display("FAIL full push+pop head: got %h exp %h", readdata, exp_rd); end
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h50) begin n_err++; $display("FAIL full push+pop status: got %h exp 50", readdata); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_reg(2'd0);
            n_cmp++; if (readdata !== exp_rd) begin n_err++; $display("FAIL full drain pop%0d: got %h exp %h", i, readdata, exp_rd); end
        end
        n_cmp++; if (readdata !== 8'hBB) begin n_err++; $display("FAIL last pop: got %h exp bb", readdata); end
    endtask

    task automatic test_peek_flush();
        push(8'h5A);
        for (int i = 0; i < 2; i++) begin
            rd_reg(2'd3);
            n_cmp++; if (readdata !== 8'h5A) begin n_err++; $display("FAIL peek%0d: got %h exp 5a", i, readdata); end
        end
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h01) begin n_err++; $display("FAIL peek count: got %h exp 01", readdata); end
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h01, 1'b1, 8'h77);
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL flush+push status: got %h exp 80", readdata); end
        // Pop on empty with a simultaneous push: returns 00, push still lands.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h3C);
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL empty pop+push data: got %h exp 00", readdata); end
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h01) begin n_err++; $display("FAIL empty pop+push status: got %h exp 01", readdata); end
        wr_ctrl(8'h01);
    endtask

    task automatic test_random();
        logic cs, rd, wr, rv;
        logic [1:0] addr;
        logic [7:0] wd;
        for (int i = 0; i < 400; i++) begin
            cs   = ($urandom_range(0, 9) != 0);
            rd   = ($urandom_range(0, 9) < 4);
            wr   = ($urandom_range(0, 19) == 0);
            addr = 2'($urandom_range(0, 3));
            wd   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
            rv   = ($urandom_range(0, 9) < 6);
            drive(cs, rd, wr, addr, wd, rv, 8'($urandom_range(0, 255)));
            n_cmp++; if (readdata !== exp_rd) begin n_err++; $display("FAIL random cycle%0d readdata: got %h exp %h", i, readdata, exp_rd); end
`ifdef CNN_RD_IRQ_EN
            n_cmp++; if (irq !== exp_irq) begin n_err++; $display("FAIL random cycle%0d irq: got %b exp %b", i, irq, exp_irq); end
`endif
        end
        wr_ctrl(8'h03);
        rd_reg(2'd1);
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL random final flush: got %h exp 80", readdata); end
    endtask

`ifdef CNN_RD_IRQ_EN
    task automatic test_irq();
        wr_ctrl(8'h07);
        push(8'h01);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq one entry: got %b exp 0", irq); end
        push(8'h02);
        n_cmp++; if (irq !== exp_irq) begin n_err++; $display("FAIL irq same cycle: got %b exp %b", irq, exp_irq); end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq two entries: got %b exp 1", irq); end
        rd_reg(2'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq after pop: got %b exp 0", irq); end
        rd_reg(2'd2);
        n_cmp++; if (readdata !== 8'h04) begin n_err++; $display("FAIL ctrl readback: got %h exp 04", readdata); end
        wr_ctrl(8'h03);
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        test_reset();
        test_order_wrap();
        test_overflow();
        test_full_push_pop();
        test_peek_flush();
`ifdef CNN_RD_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnn_result_reader.md
Name: cnn_result_reader

Overview:
- Avalon-MM slave peripheral through which the HPS reads CNN classification results back. It is the read-side counterpart of the byte-write parameter/image memory peripheral.
- The CNN core pushes 8-bit result bytes into an internal FIFO using a strobe. Software pops them through the DATA register, polls STATUS, and flushes or clears error flags through CTRL.
- Sits on the lightweight HPS-to-FPGA bridge beside the existing CNN memory peripheral, using the same 2-bit word address and 8-bit data bus.

Parameters:
- DEPTH, 16, FIFO entries; legal values 2, 4, 8, 16 (count field in STATUS is 5 bits).
- IRQ_THRESH, 1, FIFO count at or above which the interrupt asserts (only with CNN_RD_IRQ_EN); range 1..DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- chipselect  in  1  Avalon slave select.
- address  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 PEEK.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  8  write data (CTRL only).
- readdata  out  8  registered read data.
- res_data  in  8  result byte from the CNN core.
- res_valid  in  1  one-cycle push strobe; no backpressure.
- irq  out  1  level interrupt; port exists only with CNN_RD_IRQ_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, read and write pointers = 0, count = 0.
  - overflow = 0, readdata = 8'h00, irq_en = 0, irq = 0.
- All state updates on posedge clk. A bus access is chipselect && read, or chipselect && write.
- Read latency is 1: readdata is loaded on the edge that samples read and holds until the next read. read and write in the same cycle is illegal; the write is ignored.
- DATA (addr 0) read:
  - Non-empty: readdata <= head entry; head pops on the same edge (count-1, read pointer wraps modulo DEPTH).
  - Empty: readdata <= 8'h00; no state change.
- STATUS (addr 1) read: readdata <= {empty, full, overflow, count[4:0]}. No side effects.
- PEEK (addr 3) read: readdata <= head entry, or 8'h00 if empty. No pop.
- CTRL (addr 2):
  - Write bit0 = 1: flush. Pointers = 0, count = 0.
  - Write bit1 = 1: clear overflow.
  - Bit2: irq_en (with the macro only).
  - Other bits ignored. CTRL read returns {5'b0, irq_en, 2'b0}.
- Push: res_valid=1 and not full writes res_data at the write pointer; count+1; pointer wraps modulo DEPTH.
- Push when full: byte dropped, overflow <= 1 (sticky until CTRL bit1 or reset).
- Simultaneous push and DATA pop:
  - When full, the push is accepted because the pop frees a slot; count unchanged, overflow unchanged.
  - When empty, the pop returns 8'h00 and the push is accepted; count becomes 1.
- Flush and push in the same cycle: flush wins; the byte is discarded and overflow is not set.
- Flush and overflow clear in the same write both take effect.
- full = (count == DEPTH); empty = (count == 0); both combinational from count.
- Counter width is clog2(DEPTH)+1; no wrap beyond DEPTH.

Optional Feature:
- Macro CNN_RD_IRQ_EN.
- Defined:
  - irq port and irq_en bit present.
  - irq registered: irq <= irq_en && (count >= IRQ_THRESH || overflow). Asserts 1 cycle after the condition; deasserts 1 cycle after it clears.
- Undefined:
  - No irq port.
  - CTRL bit2 ignored and reads 0.
  - No extra logic.

Test Plan:
- Reset mid-traffic: push 3 bytes, pull reset low asynchronously between edges -> STATUS reads 8'h80, DATA reads 8'h00, readdata 8'h00 during reset.
- Ordering and wrap: push 8'h11, 8'h22, 8'h33, pop all, then push 16 bytes 8'h00..8'h0F (DEPTH=16) -> STATUS 8'h50, pops return 00..0F in order, final STATUS 8'h80.
- Overflow: fill 16, push 8'hAA -> STATUS 8'h70, head still 8'h00; write CTRL 8'h02 -> STATUS 8'h50.
- Full simultaneous push and pop: with FIFO full, DATA read in the same cycle as push 8'hBB -> readdata = old head, count stays 16, overflow 0, last pop returns 8'hBB.
- PEEK and flush: push 8'h5A, PEEK twice -> 8'h5A both, count 1; write CTRL 8'h01 in the same cycle as push 8'h77 -> STATUS 8'h80.
- IRQ (macro defined, IRQ_THRESH=2): irq_en=1, push 1 byte -> irq 0; push 2nd -> irq 1 one cycle later; pop 1 -> irq 0 one cycle later.
